// File: rtl/apb_cmd_initiator_pkg.sv
// Shared types for the APB command initiator: FSM state encoding and
// sizing of the ACCESS-phase wait counter.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_st_e;

  // Counter must hold 0 .. wait_timeout-1
  function automatic int tout_cnt_width(input int wait_timeout);
    return (wait_timeout > 2) ? $clog2(wait_timeout) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_initiator_intr_sync.sv
// Two-flop synchroniser for the target interrupt plus a registered
// rising-edge pulse on the synchronised level.
module apb_intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic intr_async,
  output logic intr_sync,
  output logic intr_rise
);

  logic meta_r;

  // Sync chain; the edge pulse equals intr_sync & ~(intr_sync delayed one cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r    <= 1'b0;
      intr_sync <= 1'b0;
      intr_rise <= 1'b0;
    end else begin
      meta_r    <= intr_async;
      intr_sync <= meta_r;
      intr_rise <= meta_r & ~intr_sync;
    end
  end

endmodule

// File: rtl/apb_cmd_initiator.sv
// APB4 requester: takes single read/write commands over valid/ready, runs
// SETUP/ACCESS with a wait-state timeout, and returns a one-cycle response.
module apb_cmd_initiator
  import apb_cmd_pkg::*;
#(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8,
  parameter int APB_STRBWIDTH = 4,
  parameter int WAIT_TIMEOUT  = 16
) (
  input  logic                     mclk_i,
  input  logic                     mrst_i,
  output logic                     pclk_o,
  output logic                     prst_no,
  output logic                     psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [APB_ADDRWIDTH-1:0] paddr_o,
  output logic [APB_DATAWIDTH-1:0] pwdata_o,
  output logic [APB_STRBWIDTH-1:0] pstrb_o,
  input  logic                     pready_i,
  input  logic [APB_DATAWIDTH-1:0] prdata_i,
  input  logic                     pslverr_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [APB_ADDRWIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATAWIDTH-1:0] cmd_wdata_i,
  input  logic [APB_STRBWIDTH-1:0] cmd_strb_i,
  output logic                     rsp_valid_o,
  output logic [APB_DATAWIDTH-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     rsp_tout_o,
  input  logic                     intr_i,
  output logic                     intr_o,
  output logic                     intr_rise_o
);

  localparam int CW = tout_cnt_width(WAIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  apb_st_e       state_r;
  logic [CW-1:0] wait_cnt_r;
  logic          in_access_s;
  logic          cmd_fire_s;

  assign pclk_o      = mclk_i;
  assign prst_no     = ~mrst_i;
  assign in_access_s = (state_r == ST_ACCESS);
  // A completing ACCESS can accept the next command, giving back-to-back transfers
  assign cmd_ready_o = (state_r == ST_IDLE) | (in_access_s & pready_i);
  assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;

  // Accepted command lands on the bus; lines hold their value while idle
  always_ff @(posedge mclk_i or posedge mrst_i) begin
    if (mrst_i) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (cmd_fire_s) begin
      paddr_o  <= cmd_addr_i;
      pwrite_o <= cmd_write_i;
      pwdata_o <= cmd_wdata_i;
      pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
    end else begin
      paddr_o  <= paddr_o;
      pwrite_o <= pwrite_o;
      pwdata_o <= pwdata_o;
      pstrb_o  <= pstrb_o;
    end
  end

  // Phase FSM with wait-state timeout and the registered response pulse
  always_ff @(posedge mclk_i or posedge mrst_i) begin
    if (mrst_i) begin
      state_r     <= ST_IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      wait_cnt_r  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tout_o  <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tout_o  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          penable_o <= 1'b0;
          if (cmd_valid_i) begin
            state_r    <= ST_SETUP;
            psel_o     <= 1'b1;
            wait_cnt_r <= '0;
          end else begin
            psel_o <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_r   <= ST_ACCESS;
          psel_o    <= 1'b1;
          penable_o <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= pslverr_i;
            penable_o   <= 1'b0;
            if (cmd_valid_i) begin
              state_r    <= ST_SETUP;
              psel_o     <= 1'b1;
              wait_cnt_r <= '0;
            end else begin
              state_r <= ST_IDLE;
              psel_o  <= 1'b0;
            end
          end else if (wait_cnt_r == CNT_LAST) begin
            // Target never answered: abandon the transfer and report it
            state_r     <= ST_IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_tout_o  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

  apb_intr_sync u_intr_sync (
    .clk        (mclk_i),
    .rst        (mrst_i),
    .intr_async (intr_i),
    .intr_sync  (intr_o),
    .intr_rise  (intr_rise_o)
  );

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator: programmable APB target with per-transfer
// wait states/error/read data, and a transaction-level expectation model.
module tb_apb_cmd_initiator;
  localparam int AW = 16, DW = 8, SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          pclk_o, prst_no, psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          intr_in = 1'b0, intr_o, intr_rise_o;

  apb_cmd_initiator #(.APB_ADDRWIDTH(AW), .APB_DATAWIDTH(DW), .APB_STRBWIDTH(SW), .WAIT_TIMEOUT(16)) dut (
    .mclk_i(clk), .mrst_i(rst), .pclk_o(pclk_o), .prst_no(prst_no),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
    .pslverr_i(pslverr_i), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .cmd_strb_i(cmd_strb), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_tout_o(rsp_tout_o), .intr_i(intr_in),
    .intr_o(intr_o), .intr_rise_o(intr_rise_o)
  );

  // Target model: transfer n (counted by SETUP phases) uses cfg slot n
  int            cfg_wait [256];
  logic          cfg_err  [256];
  logic [DW-1:0] cfg_rdata[256];
  int            acc_cnt, setup_cnt, cap_cnt;
  logic [AW-1:0] cap_addr [256];
  logic          cap_write[256];
  logic [DW-1:0] cap_wdata[256];
  logic [SW-1:0] cap_strb [256];
  logic [7:0]    cur_idx;

  assign cur_idx   = 8'(setup_cnt - 1);
  assign pready_i  = psel_o & penable_o & (acc_cnt >= cfg_wait[cur_idx]);
  assign prdata_i  = cfg_rdata[cur_idx];
  assign pslverr_i = cfg_err[cur_idx];

  always @(posedge clk) begin
    acc_cnt <= (psel_o && penable_o && !pready_i) ? acc_cnt + 1 : 0;
    if (psel_o && !penable_o) setup_cnt <= setup_cnt + 1;
    if (psel_o && penable_o && pready_i) begin
      cap_addr[8'(cap_cnt)]  <= paddr_o;
      cap_write[8'(cap_cnt)] <= pwrite_o;
      cap_wdata[8'(cap_cnt)] <= pwdata_o;
      cap_strb[8'(cap_cnt)]  <= pstrb_o;
      cap_cnt <= cap_cnt + 1;
    end
  end

  int n_checks = 0, n_fail = 0;

  // Command list and observed results of one run_seq call
  logic          c_write[64];
  logic [AW-1:0] c_addr [64];
  logic [DW-1:0] c_wdata[64];
  logic [SW-1:0] c_strb [64];
  int            a_cyc[64], r_cyc[64], n_rsp;
  logic [DW-1:0] r_rdata[64];
  logic          r_err[64], r_tout[64];
  logic          psel_tr[2048], pen_tr[2048];

  task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    c_write[i] = wr; c_addr[i] = a; c_wdata[i] = d; c_strb[i] = s;
  endtask

  task automatic set_cfg(input int slot, input int w, input logic e, input logic [DW-1:0] rd);
    cfg_wait[8'(slot)] = w; cfg_err[8'(slot)] = e; cfg_rdata[8'(slot)] = rd;
  endtask

  // Presents commands continuously, recording accept/response cycles and a bus trace
  task automatic run_seq(input int n);
    int sent, k, max_cyc;
    sent = 0; k = 0; n_rsp = 0; max_cyc = n * 25 + 10;
    while (n_rsp < n && k < max_cyc) begin
      @(negedge clk);
      psel_tr[k] = psel_o; pen_tr[k] = penable_o;
      if (rsp_valid_o && n_rsp < 64) begin
        r_cyc[n_rsp] = k; r_rdata[n_rsp] = rsp_rdata_o;
        r_err[n_rsp] = rsp_err_o; r_tout[n_rsp] = rsp_tout_o;
        n_rsp++;
      end
      if (sent < n) begin
        cmd_valid = 1'b1; cmd_write = c_write[sent]; cmd_addr = c_addr[sent];
        cmd_wdata = c_wdata[sent]; cmd_strb = c_strb[sent];
        if (cmd_ready_o) begin a_cyc[sent] = k; sent++; end
      end else begin
        cmd_valid = 1'b0;
      end
      k++;
    end
    cmd_valid = 1'b0;
  endtask

  function automatic int pen_count(input int i);
    int c = 0;
    for (int j = a_cyc[i] + 1; j < r_cyc[i]; j++) c += pen_tr[j] ? 1 : 0;
    return c;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin n_fail++; $display("FAIL rst_ctrl: got %b expected 000", {psel_o, penable_o, pwrite_o}); end
    n_checks++; if ({paddr_o, pwdata_o, pstrb_o} !== 28'h0) begin n_fail++; $display("FAIL rst_bus: got %0h expected 0", {paddr_o, pwdata_o, pstrb_o}); end
    n_checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tout_o} !== 11'h0) begin n_fail++; $display("FAIL rst_rsp: got %0h expected 0", {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tout_o}); end
    n_checks++; if ({intr_o, intr_rise_o} !== 2'b00) begin n_fail++; $display("FAIL rst_intr: got %b expected 00", {intr_o, intr_rise_o}); end
    n_checks++; if (prst_no !== 1'b0) begin n_fail++; $display("FAIL rst_prst: got %b expected 0", prst_no); end
    n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cmd_ready_o); end
    n_checks++; if (pclk_o !== clk) begin n_fail++; $display("FAIL pclk: got %b expected %b", pclk_o, clk); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (prst_no !== 1'b1) begin n_fail++; $display("FAIL prst_rel: got %b expected 1", prst_no); end
  endtask

  task automatic test_write();
    int b = setup_cnt, cb = cap_cnt;
    set_cfg(b, 0, 1'b0, 8'hAA);
    set_cmd(0, 1'b1, 16'h0019, 8'h08, 4'hF);
    run_seq(1);
    n_checks++; if (n_rsp !== 1) begin n_fail++; $display("FAIL wr_nrsp: got %0d expected 1", n_rsp); end
    n_checks++; if (r_cyc[0] - a_cyc[0] !== 3) begin n_fail++; $display("FAIL wr_lat: got %0d expected 3", r_cyc[0] - a_cyc[0]); end
    n_checks++; if ({psel_tr[a_cyc[0]+1], pen_tr[a_cyc[0]+1]} !== 2'b10) begin n_fail++; $display("FAIL wr_setup: got %b expected 10", {psel_tr[a_cyc[0]+1], pen_tr[a_cyc[0]+1]}); end
    n_checks++; if ({psel_tr[a_cyc[0]+2], pen_tr[a_cyc[0]+2]} !== 2'b11) begin n_fail++; $display("FAIL wr_access: got %b expected 11", {psel_tr[a_cyc[0]+2], pen_tr[a_cyc[0]+2]}); end
    n_checks++; if ({r_rdata[0], r_err[0], r_tout[0]} !== 10'h0) begin n_fail++; $display("FAIL wr_rsp: got %0h expected 0", {r_rdata[0], r_err[0], r_tout[0]}); end
    n_checks++; if (psel_tr[r_cyc[0]] !== 1'b0) begin n_fail++; $display("FAIL wr_idle_psel: got %b expected 0", psel_tr[r_cyc[0]]); end
    n_checks++; if ({cap_addr[8'(cb)], cap_write[8'(cb)], cap_wdata[8'(cb)], cap_strb[8'(cb)]} !== {16'h0019, 1'b1, 8'h08, 4'hF}) begin n_fail++; $display("FAIL wr_bus: got %0h expected %0h", {cap_addr[8'(cb)], cap_write[8'(cb)], cap_wdata[8'(cb)], cap_strb[8'(cb)]}, {16'h0019, 1'b1, 8'h08, 4'hF}); end
    @(negedge clk);
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b expected 0", rsp_valid_o); end
  endtask

  task automatic test_wait_read();
    int b = setup_cnt, cb = cap_cnt;
    set_cfg(b, 3, 1'b0, 8'h01);
    set_cmd(0, 1'b0, 16'h0040, 8'h77, 4'hF);
    run_seq(1);
    n_checks++; if (r_cyc[0] - a_cyc[0] !== 6) begin n_fail++; $display("FAIL rd_lat: got %0d expected 6", r_cyc[0] - a_cyc[0]); end
    n_checks++; if (pen_count(0) !== 4) begin n_fail++; $display("FAIL rd_penable: got %0d expected 4", pen_count(0)); end
    n_checks++; if ({r_rdata[0], r_err[0], r_tout[0]} !== {8'h01, 2'b00}) begin n_fail++; $display("FAIL rd_rsp: got %0h expected %0h", {r_rdata[0], r_err[0], r_tout[0]}, {8'h01, 2'b00}); end
    n_checks++; if ({cap_write[8'(cb)], cap_strb[8'(cb)]} !== 5'h0) begin n_fail++; $display("FAIL rd_strb: got %0h expected 0", {cap_write[8'(cb)], cap_strb[8'(cb)]}); end
  endtask

  task automatic test_back_to_back();
    int b = setup_cnt, gaps = 0;
    set_cfg(b, 0, 1'b0, 8'h00);
    set_cfg(b + 1, 0, 1'b0, 8'h00);
    set_cmd(0, 1'b1, 16'h0019, 8'h08, 4'hF);
    set_cmd(1, 1'b1, 16'h0040, 8'h01, 4'h3);
    run_seq(2);
    n_checks++; if (n_rsp !== 2) begin n_fail++; $display("FAIL b2b_nrsp: got %0d expected 2", n_rsp); end
    n_checks++; if (a_cyc[1] - a_cyc[0] !== 2) begin n_fail++; $display("FAIL b2b_accept: got %0d expected 2", a_cyc[1] - a_cyc[0]); end
    n_checks++; if (r_cyc[1] - a_cyc[0] !== 5) begin n_fail++; $display("FAIL b2b_total: got %0d expected 5", r_cyc[1] - a_cyc[0]); end
    for (int j = a_cyc[0] + 1; j < r_cyc[1]; j++) gaps += psel_tr[j] ? 0 : 1;
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_psel: got %0d low cycles expected 0", gaps); end
    n_checks++; if (pen_tr[a_cyc[1]+1] !== 1'b0) begin n_fail++; $display("FAIL b2b_pen_drop: got %b expected 0", pen_tr[a_cyc[1]+1]); end
    n_checks++; if ({r_err[0], r_err[1]} !== 2'b00) begin n_fail++; $display("FAIL b2b_err: got %b expected 00", {r_err[0], r_err[1]}); end
    n_checks++; if ({cap_addr[8'(cap_cnt-1)], cap_wdata[8'(cap_cnt-1)], cap_strb[8'(cap_cnt-1)]} !== {16'h0040, 8'h01, 4'h3}) begin n_fail++; $display("FAIL b2b_bus2: got %0h expected %0h", {cap_addr[8'(cap_cnt-1)], cap_wdata[8'(cap_cnt-1)], cap_strb[8'(cap_cnt-1)]}, {16'h0040, 8'h01, 4'h3}); end
  endtask

  // Stuck target, then exactly 15 wait states (completes), then 16 (aborts)
  task automatic test_timeout();
    int b = setup_cnt, cb = cap_cnt;
    set_cfg(b, 1000, 1'b0, 8'hC3);
    set_cfg(b + 1, 15, 1'b0, 8'h5E);
    set_cfg(b + 2, 16, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) set_cmd(i, 1'b0, 16'h0040 + 16'(i), 8'h00, 4'h0);
    run_seq(3);
    n_checks++; if (n_rsp !== 3) begin n_fail++; $display("FAIL to_nrsp: got %0d expected 3", n_rsp); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (r_cyc[i] - a_cyc[i] !== 18) begin n_fail++; $display("FAIL to_lat%0d: got %0d expected 18", i, r_cyc[i] - a_cyc[i]); end
      n_checks++; if (pen_count(i) !== 16) begin n_fail++; $display("FAIL to_pen%0d: got %0d expected 16", i, pen_count(i)); end
    end
    n_checks++; if ({r_rdata[0], r_err[0], r_tout[0]} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL to_abort: got %0h expected %0h", {r_rdata[0], r_err[0], r_tout[0]}, {8'h00, 2'b11}); end
    n_checks++; if (psel_tr[r_cyc[0]] !== 1'b0) begin n_fail++; $display("FAIL to_psel: got %b expected 0", psel_tr[r_cyc[0]]); end
    n_checks++; if ({r_rdata[1], r_err[1], r_tout[1]} !== {8'h5E, 2'b00}) begin n_fail++; $display("FAIL to_w15: got %0h expected %0h", {r_rdata[1], r_err[1], r_tout[1]}, {8'h5E, 2'b00}); end
    n_checks++; if ({r_rdata[2], r_err[2], r_tout[2]} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL to_w16: got %0h expected %0h", {r_rdata[2], r_err[2], r_tout[2]}, {8'h00, 2'b11}); end
    n_checks++; if (cap_cnt - cb !== 1) begin n_fail++; $display("FAIL to_caps: got %0d expected 1", cap_cnt - cb); end
  endtask

  task automatic test_slverr();
    int b = setup_cnt;
    set_cfg(b, 0, 1'b1, 8'h99);
    set_cfg(b + 1, 1, 1'b0, 8'h5A);
    set_cmd(0, 1'b1, 16'hFFF0, 8'h12, 4'hF);
    set_cmd(1, 1'b0, 16'h0040, 8'h00, 4'h0);
    run_seq(2);
    n_checks++; if ({r_rdata[0], r_err[0], r_tout[0]} !== {8'h00, 2'b10}) begin n_fail++; $display("FAIL se_err: got %0h expected %0h", {r_rdata[0], r_err[0], r_tout[0]}, {8'h00, 2'b10}); end
    n_checks++; if ({r_rdata[1], r_err[1], r_tout[1]} !== {8'h5A, 2'b00}) begin n_fail++; $display("FAIL se_next: got %0h expected %0h", {r_rdata[1], r_err[1], r_tout[1]}, {8'h5A, 2'b00}); end
    n_checks++; if (r_cyc[1] - a_cyc[1] !== 4) begin n_fail++; $display("FAIL se_lat: got %0d expected 4", r_cyc[1] - a_cyc[1]); end
  endtask

  task automatic test_intr();
    @(negedge clk); intr_in = 1'b1;
    @(negedge clk);
    n_checks++; if ({intr_o, intr_rise_o} !== 2'b00) begin n_fail++; $display("FAIL intr_c1: got %b expected 00", {intr_o, intr_rise_o}); end
    @(negedge clk);
    n_checks++; if ({intr_o, intr_rise_o} !== 2'b11) begin n_fail++; $display("FAIL intr_c2: got %b expected 11", {intr_o, intr_rise_o}); end
    @(negedge clk);
    n_checks++; if ({intr_o, intr_rise_o} !== 2'b10) begin n_fail++; $display("FAIL intr_c3: got %b expected 10", {intr_o, intr_rise_o}); end
    intr_in = 1'b0;
    @(negedge clk);
    n_checks++; if (intr_rise_o !== 1'b0) begin n_fail++; $display("FAIL intr_fall1: got %b expected 0", intr_rise_o); end
    @(negedge clk);
    n_checks++; if ({intr_o, intr_rise_o} !== 2'b00) begin n_fail++; $display("FAIL intr_fall2: got %b expected 00", {intr_o, intr_rise_o}); end
  endtask

  task automatic test_reset_mid();
    int b = setup_cnt, found = 0, pulses = 0;
    set_cfg(b, 10, 1'b0, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0022; cmd_wdata = 8'h44; cmd_strb = 4'hF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (penable_o) found = 1;
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL rm_access: got %0d expected 1", found); end
    rst = 1'b1; #1;
    n_checks++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b000) begin n_fail++; $display("FAIL rm_drop: got %b expected 000", {psel_o, penable_o, rsp_valid_o}); end
    n_checks++; if (paddr_o !== 16'h0) begin n_fail++; $display("FAIL rm_addr: got %0h expected 0", paddr_o); end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin @(negedge clk); pulses += rsp_valid_o ? 1 : 0; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_norsp: got %0d expected 0", pulses); end
  endtask

  task automatic test_random();
    int b = setup_cnt, cb = cap_cnt, w[40], j;
    logic te[40];
    int exp_lat, exp_pen, exp_acc;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 40; i++) begin
      set_cmd(i, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 4'($urandom));
      w[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      te[i] = (w[i] >= 16);
      set_cfg(b + i, w[i], ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    run_seq(40);
    n_checks++; if (n_rsp !== 40) begin n_fail++; $display("FAIL rnd_nrsp: got %0d expected 40", n_rsp); end
    for (int i = 0; i < 40 && i < n_rsp; i++) begin
      exp_lat = 3 + (te[i] ? 15 : w[i]);
      exp_pen = te[i] ? 16 : w[i] + 1;
      exp_rd  = (te[i] || c_write[i]) ? 8'h00 : cfg_rdata[8'(b + i)];
      n_checks++; if (r_cyc[i] - a_cyc[i] !== exp_lat) begin n_fail++; $display("FAIL rnd_lat%0d: got %0d expected %0d", i, r_cyc[i] - a_cyc[i], exp_lat); end
      n_checks++; if (pen_count(i) !== exp_pen) begin n_fail++; $display("FAIL rnd_pen%0d: got %0d expected %0d", i, pen_count(i), exp_pen); end
      n_checks++; if ({r_rdata[i], r_err[i], r_tout[i]} !== {exp_rd, te[i] | cfg_err[8'(b + i)], te[i]}) begin n_fail++; $display("FAIL rnd_rsp%0d: got %0h expected %0h", i, {r_rdata[i], r_err[i], r_tout[i]}, {exp_rd, te[i] | cfg_err[8'(b + i)], te[i]}); end
      if (i > 0) begin
        exp_acc = r_cyc[i-1] - (te[i-1] ? 0 : 1);
        n_checks++; if (a_cyc[i] !== exp_acc) begin n_fail++; $display("FAIL rnd_acc%0d: got %0d expected %0d", i, a_cyc[i], exp_acc); end
      end
    end
    j = 0;
    for (int i = 0; i < 40; i++) begin
      if (!te[i]) begin
        n_checks++;
        if ({cap_addr[8'(cb + j)], cap_write[8'(cb + j)], cap_strb[8'(cb + j)]} !== {c_addr[i], c_write[i], c_write[i] ? c_strb[i] : 4'h0}
            || (c_write[i] && cap_wdata[8'(cb + j)] !== c_wdata[i])) begin
          n_fail++; $display("FAIL rnd_bus%0d: got %0h expected %0h", i, {cap_addr[8'(cb + j)], cap_write[8'(cb + j)], cap_wdata[8'(cb + j)], cap_strb[8'(cb + j)]}, {c_addr[i], c_write[i], c_wdata[i], c_strb[i]});
        end
        j++;
      end
    end
    n_checks++; if (cap_cnt - cb !== j) begin n_fail++; $display("FAIL rnd_caps: got %0d expected %0d", cap_cnt - cb, j); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin cfg_wait[i] = 0; cfg_err[i] = 1'b0; cfg_rdata[i] = 8'h00; end
    test_reset();
    test_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_intr();
    test_reset_mid();
    test_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
